// File: rtl/axi_rd_resp_pkg.sv
// Shared AXI encodings and helpers for the read responder.
package axi_rd_resp_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Only FIXED and INCR are walked; WRAP and the reserved code are rejected.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_rd_resp_if.sv
// AXI read address and read data channels, reduced to the signals the responder uses.
interface axi_ar #(
  parameter int ID_WIDTH = 5
);
  logic                arvalid;
  logic                arready;
  logic [63:0]         araddr;
  logic [7:0]          arlen;
  logic [1:0]          arburst;
  logic [ID_WIDTH-1:0] arid;

  modport master (output arvalid, araddr, arlen, arburst, arid, input arready);
  modport slave  (input arvalid, araddr, arlen, arburst, arid, output arready);
endinterface

interface axi_r #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 5
);
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic [ID_WIDTH-1:0]   rid;
  logic                  rlast;

  modport master (output rvalid, rdata, rresp, rid, rlast, input rready);
  modport slave  (input rvalid, rdata, rresp, rid, rlast, output rready);
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Beat address and beat counter for one FIXED/INCR burst.
module axi_burst_addr_gen
  import axi_rd_resp_pkg::*;
#(
  parameter int DATA_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [63:0] addr,
  input  logic [1:0]  burst,
  input  logic [7:0]  len,
  output logic [63:0] beat_addr,
  output logic        last
);

  localparam logic [63:0] BEAT_STEP  = 64'(DATA_BYTES);
  localparam logic [63:0] ALIGN_MASK = ~(BEAT_STEP - 64'd1);

  logic [7:0] cnt;

  // Load the aligned start address on AR accept; advance once per accepted non-last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_addr <= '0;
      cnt       <= '0;
    end else if (load) begin
      beat_addr <= addr & ALIGN_MASK;
      cnt       <= '0;
    end else if (step) begin
      cnt <= cnt + 8'd1;
      if (burst == AXI_BURST_INCR) beat_addr <= beat_addr + BEAT_STEP;
    end
  end

  assign last = (cnt == len);

endmodule

// File: rtl/axi_rd_resp.sv
// Single-outstanding AXI read responder over a 1-cycle-latency memory port.
module axi_rd_resp
  import axi_rd_resp_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int          SIZE_LOG2  = 16,
  parameter int          ID_WIDTH   = 5
) (
  input  logic                  axi_rd_resp_clk_i,
  input  logic                  axi_rd_resp_arst_i,
  axi_ar.slave                  axi_rd_resp_ar,
  axi_r.master                  axi_rd_resp_r,
  output logic                  mem_rd_o,
  output logic [SIZE_LOG2-4:0]  mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int DATA_BYTES = DATA_WIDTH / 8;

  // IDLE  | waiting for AR, arready high
  // ISSUE | classify beat, strobe memory for OKAY beats
  // CAPT  | capture memory data (or zero) and rlast
  // RESP  | hold R beat until rready
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  load, step, arready, rvalid, mem_rd;
  logic [63:0]           beat_addr;
  logic                  beat_last;
  logic [1:0]            beat_resp;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic [1:0]            resp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rlast_q;

  axi_burst_addr_gen #(.DATA_BYTES(DATA_BYTES)) u_addr_gen (
    .clk       (axi_rd_resp_clk_i),
    .rst       (axi_rd_resp_arst_i),
    .load      (load),
    .step      (step),
    .addr      (axi_rd_resp_ar.araddr),
    .burst     (burst_q),
    .len       (len_q),
    .beat_addr (beat_addr),
    .last      (beat_last)
  );

  // Per-beat classification; burst errors take precedence over window misses.
  always_comb begin
    beat_resp = AXI_RESP_OKAY;
    if (!burst_supported(burst_q))                            beat_resp = AXI_RESP_SLVERR;
    else if ((beat_addr >> SIZE_LOG2) != (BASE_ADDR >> SIZE_LOG2)) beat_resp = AXI_RESP_DECERR;
  end

  // State register.
  always_ff @(posedge axi_rd_resp_clk_i or posedge axi_rd_resp_arst_i) begin
    if (axi_rd_resp_arst_i) state_q <= IDLE;
    else                    state_q <= state_d;
  end

  // Next state and handshake/strobe outputs, all derived from state only (plus rready for moves).
  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    rvalid  = 1'b0;
    mem_rd  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        arready = 1'b1;
        if (axi_rd_resp_ar.arvalid) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd  = (beat_resp == AXI_RESP_OKAY);
        state_d = CAPT;
      end
      CAPT: state_d = RESP;
      RESP: begin
        rvalid = 1'b1;
        if (axi_rd_resp_r.rready) begin
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            step    = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction attributes and the registered R beat.
  always_ff @(posedge axi_rd_resp_clk_i or posedge axi_rd_resp_arst_i) begin
    if (axi_rd_resp_arst_i) begin
      id_q    <= '0;
      len_q   <= '0;
      burst_q <= '0;
      resp_q  <= AXI_RESP_OKAY;
      rdata_q <= '0;
      rlast_q <= 1'b0;
    end else begin
      if (load) begin
        id_q    <= axi_rd_resp_ar.arid;
        len_q   <= axi_rd_resp_ar.arlen;
        burst_q <= axi_rd_resp_ar.arburst;
      end
      if (state_q == ISSUE) resp_q <= beat_resp;
      if (state_q == CAPT) begin
        rdata_q <= (resp_q == AXI_RESP_OKAY) ? mem_rdata_i : '0;
        rlast_q <= beat_last;
      end
    end
  end

  assign axi_rd_resp_ar.arready = arready;
  assign axi_rd_resp_r.rvalid   = rvalid;
  assign axi_rd_resp_r.rdata    = rdata_q;
  assign axi_rd_resp_r.rresp    = resp_q;
  assign axi_rd_resp_r.rid      = id_q;
  assign axi_rd_resp_r.rlast    = rlast_q;
  assign mem_rd_o               = mem_rd;
  assign mem_addr_o             = beat_addr[SIZE_LOG2-1:3];

endmodule

// File: doc/axi_rd_resp.md
# axi_rd_resp

AXI read-channel responder (slave) serving AR/R requests from read initiators such as the page table walker and the instruction/data refill paths. It accepts one read transaction at a time, walks FIXED or INCR bursts beat by beat against a synchronous 1-cycle-latency memory port, and returns R beats with the requester's ID echoed. Addresses outside the configured window get DECERR; unsupported bursts get SLVERR. It sits between the bus crossbar and a boot ROM or on-chip RAM.

## Interface
- `DATA_WIDTH`, 64: R data width in bits. Beat size is `DATA_BYTES = DATA_WIDTH/8`.
- `BASE_ADDR`, 64'h0: window base address, aligned to 2^`SIZE_LOG2`.
- `SIZE_LOG2`, 16: window size is 2^`SIZE_LOG2` bytes.
- `ID_WIDTH`, 5: width of `arid`/`rid`.
---
- `axi_rd_resp_clk_i`  in  1  clock; everything is rising-edge.
- `axi_rd_resp_arst_i`  in  1  reset, asynchronous, active-high.
- `axi_rd_resp_ar`  axi_ar.slave  —  AR channel. Uses `arvalid`, `arready`, `araddr`, `arlen`, `arburst`, `arid`. `arsize`, `arlock`, `arcache`, `arprot`, `arqos` and `arregion` are ignored.
- `axi_rd_resp_r`  axi_r.master  —  R channel: `rvalid`, `rready`, `rdata`, `rresp`, `rid`, `rlast`.
- `mem_rd_o`  out  1  memory read strobe.
- `mem_addr_o`  out  SIZE_LOG2-3  memory word index, `beat_addr[SIZE_LOG2-1:3]`.
- `mem_rdata_i`  in  DATA_WIDTH  read data. Valid in the cycle after `mem_rd_o`.

## Operation
- States: IDLE, ISSUE, CAPT, RESP.
- **IDLE**
  - `arready`=1.
  - On `arvalid`, latch `arid`, `arlen`, `arburst` and `araddr & ~(DATA_BYTES-1)` into `beat_addr`.
  - Clear the beat counter `cnt`, then go to ISSUE.
- **ISSUE**
  - Evaluate the beat error:
    - `arburst`==WRAP or reserved: SLVERR.
    - Otherwise, `beat_addr[63:SIZE_LOG2] != BASE_ADDR[63:SIZE_LOG2]`: DECERR.
    - Otherwise: OKAY.
  - `mem_rd_o` is 1 only if the beat is OKAY. Register the resp, then go to CAPT.
- **CAPT**
  - Load the `rdata` register with `mem_rdata_i` for an OKAY beat, or with 0 for an error beat.
  - Set `rlast = (cnt==arlen)`, then go to RESP.
- **RESP**
  - `rvalid`=1. `rdata`, `rresp`, `rid` and `rlast` stay stable until `rready`.
  - On `rready`, if `rlast`, go to IDLE.
  - On `rready`, if not `rlast`:
    - `cnt++`.
    - For INCR, `beat_addr += DATA_BYTES` (64-bit wrap, no 4 KB check). For FIXED, `beat_addr` is unchanged.
    - Go to ISSUE.
- Error checks are per beat. An INCR burst that crosses the window top returns OKAY beats followed by DECERR beats. Every burst returns exactly `arlen+1` beats.
- `arready` is 0 outside IDLE, so there is only one outstanding transaction.
- Reset values:
  - State = IDLE.
  - Outputs: `arready`=1 (comb from IDLE), `rvalid`=0, `rlast`=0, `rresp`=OKAY, `rid`=0, `rdata`=0, `mem_rd_o`=0, `mem_addr_o`=0.
- Reset mid-transaction drops the transaction silently. No beats are emitted after reset.

## Timing
- AR handshake in cycle T:
  - T+1: ISSUE, `mem_rd_o`.
  - T+2: CAPT.
  - T+3: first `rvalid`.
- R handshake in cycle U (not last):
  - U+1: ISSUE.
  - U+3: next `rvalid`.
- Full-rate throughput is 1 beat per 3 cycles. An `rready` stall extends RESP with no loss.
- Earliest new `arready` is the cycle after the last R handshake, i.e. IDLE at U+1.
- `rvalid` never depends combinationally on `rready`. `arready` depends only on the state.

## Structure
- Use `AXI_RESP_*` and `AXI_BURST_*` from prv664_bus_define.svh. Add `AXI_RESP_SLVERR` and `AXI_RESP_DECERR` there if missing.
- Keep the state encoding local as a localparam enum.
- One sub-module, `axi_burst_addr_gen`: holds `beat_addr` and `cnt`; inputs load/step/burst/len; outputs `beat_addr` and `last`.

## Test plan
- Single beat in window: araddr=BASE+0x40, arlen=0, INCR, arid=5'h03, memory word[8]=64'hDEADBEEF_0000_0001 -> one beat at T+3 with that rdata, OKAY, rid=3, rlast=1; `mem_addr_o`=8 with `mem_rd_o` at T+1.
- INCR arlen=3 at BASE+0x10, `rready` low for 4 cycles on beat 1 -> words 2,3,4,5 in order; beat 1 held stable through the stall; rlast only on beat 3.
- FIXED arlen=2 at BASE+0x8 -> 3 beats, all word 1; `mem_addr_o`=1 each time.
- Out of window: araddr=BASE+2^SIZE_LOG2, arlen=1 -> 2 beats DECERR, rdata=0, `mem_rd_o` never asserted. INCR starting at the last window word with arlen=1 -> OKAY then DECERR.
- WRAP burst arlen=3 -> 4 beats SLVERR, rdata 0, rlast on the 4th; `arready` low throughout.
- Assert `axi_rd_resp_arst_i` while in RESP of beat 1 of 4 -> `rvalid`=0 immediately; after release `arready`=1 and no stale beats; a new AR returns correct data.
